// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// FetchSequencer (top: fetch_sequencer)
//
// Purpose:
//   Owns the fetch PC and runs a single-outstanding request/grant/response
//   handshake with instruction memory. It arbitrates the execute-stage
//   redirect (branch/JALR) against the decode-stage redirect (JAL) and drops
//   fetches that were squashed while in flight, so they never reach decode.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   ex_redirect_i/target execute-stage redirect request and target
//   id_redirect_i/target decode-stage redirect request and target
//   imem_req_o           fetch request to instruction memory
//   imem_addr_o          fetch address (always equals pc_o)
//   imem_gnt_i           memory accepted the request this cycle
//   imem_rvalid_i        response data valid
//   imem_rdata_i         response instruction word
//   instr_valid_o        buffered instruction presented to decode
//   instr_o, instr_pc_o  buffered instruction and its address
//   instr_ready_i        decode accepts the buffered instruction
//   pc_o                 current fetch PC
//   flush_o              redirect accepted this cycle (combinational)
//   misalign_o           one-cycle pulse after accepting a misaligned target
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned          ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_redirect_i,
    input  logic [ADDR_W-1:0]   ex_target_i,
    input  logic                id_redirect_i,
    input  logic [ADDR_W-1:0]   id_target_i,
    output logic                imem_req_o,
    output logic [ADDR_W-1:0]   imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    output logic [31:0]         instr_o,
    output logic [ADDR_W-1:0]   instr_pc_o,
    input  logic                instr_ready_i,
    output logic [ADDR_W-1:0]   pc_o,
    output logic                flush_o,
    output logic                misalign_o
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               kill_q;
    logic               req_q;
    logic               valid_q;
    logic [31:0]        instr_q;
    logic [ADDR_W-1:0]  instrPc_q;
    logic               misalign_q;

    logic               redirAccept;
    logic [ADDR_W-1:0]  redirTarget;
    logic [ADDR_W-1:0]  alignedTarget;
    logic               redirMisaligned;
    logic [ADDR_W-1:0]  pcPlus4;

    // Redirect arbitration. The execute-stage request wins because its
    // instruction is older than the one in decode. Nothing is accepted while
    // IDLE, which is only the single cycle straight out of reset. The low two
    // bits of the target are cleared for fetch, but remembered so a
    // misaligned target can be reported one cycle later.
    always_comb begin
        redirTarget     = ex_redirect_i ? ex_target_i : id_target_i;
        redirAccept     = (state_q != IDLE) && (ex_redirect_i || id_redirect_i);
        redirMisaligned = (redirTarget[1:0] != 2'b00);
        alignedTarget   = {redirTarget[ADDR_W-1:2], 2'b00};
        pcPlus4         = pc_q + ADDR_W'(4);
    end

    // Fetch FSM with all outputs registered. A redirect always overwrites the
    // PC, whatever the state. The kill flag marks a response that belongs to
    // an address that has since been redirected away from; that response is
    // swallowed in WAIT instead of being handed to decode. In HOLD a redirect
    // takes precedence over the sequential +4 step even if decode is ready,
    // so the buffered instruction is dropped rather than delivered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            kill_q     <= 1'b0;
            req_q      <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= '0;
            instrPc_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= redirAccept && redirMisaligned;

            if (redirAccept) begin
                pc_q <= alignedTarget;
            end

            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end

                REQ: begin
                    if (imem_gnt_i) begin
                        state_q <= WAIT;
                        req_q   <= 1'b0;
                        kill_q  <= redirAccept;
                    end
                end

                WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q || redirAccept) begin
                            kill_q  <= 1'b0;
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end else begin
                            instr_q   <= imem_rdata_i;
                            instrPc_q <= pc_q;
                            valid_q   <= 1'b1;
                            state_q   <= HOLD;
                        end
                    end else if (redirAccept) begin
                        kill_q <= 1'b1;
                    end
                end

                HOLD: begin
                    if (redirAccept) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end else if (instr_ready_i) begin
                        pc_q    <= pcPlus4;
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    kill_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instrPc_q;
    assign flush_o       = redirAccept;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for fetch_sequencer. Stimulus pushes the expected memory request
// addresses and expected decode hand-offs into queues; an independent
// monitor pops and compares them whenever the DUT presents a granted request
// or an accepted instruction. Cycle-specific behaviour (reset values, flush,
// misalign, backpressure, squash) is checked directly in the stimulus.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        ex_redirect_i;
    logic [15:0] ex_target_i;
    logic        id_redirect_i;
    logic [15:0] id_target_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [15:0] instr_pc_o;
    logic        instr_ready_i;
    logic [15:0] pc_o;
    logic        flush_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    logic [15:0] expReqQ[$];
    logic [47:0] expInstrQ[$];
    logic [15:0] monExpAddr;
    logic [47:0] monExpInstr;

    fetch_sequencer #(
        .ADDR_W   (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .id_redirect_i (id_redirect_i),
        .id_target_i   (id_target_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .pc_o          (pc_o),
        .flush_o       (flush_o),
        .misalign_o    (misalign_o)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something deadlocks despite the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive every DUT input for the coming cycle.
    task automatic applyStimulus(input logic gnt, input logic rvalid,
                                 input logic [31:0] rdata, input logic ready,
                                 input logic exR, input logic [15:0] exT,
                                 input logic idR, input logic [15:0] idT);
        imem_gnt_i    = gnt;
        imem_rvalid_i = rvalid;
        imem_rdata_i  = rdata;
        instr_ready_i = ready;
        ex_redirect_i = exR;
        ex_target_i   = exT;
        id_redirect_i = idR;
        id_target_i   = idT;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until the DUT raises a fetch request.
    task automatic waitReq(input logic [15:0] addrHint);
        int n = 0;
        while (!imem_req_o && n < 20) begin
            applyIdle();
            step();
            n++;
        end
        if (!imem_req_o) begin
            checks++;
            errors++;
            $display("[TB] FAIL reqTimeout: imem_req_o still 0, expected request for %h", addrHint);
        end
    endtask

    // One complete fetch: grant immediately, respond on the next cycle, then
    // keep decode stalled for holdCycles before accepting.
    task automatic fetchOne(input logic [15:0] addr, input logic [31:0] data,
                            input int holdCycles);
        waitReq(addr);
        expReqQ.push_back(addr);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        expInstrQ.push_back({addr, data});
        applyStimulus(1'b0, 1'b1, data, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        for (int i = 0; i < holdCycles; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
            #1;
            checkOutput("holdValid", 32'(instr_valid_o), 32'd1);
            checkOutput("holdInstr", instr_o, data);
            checkOutput("holdPc", 32'(instr_pc_o), 32'(addr));
            checkOutput("holdNoReq", 32'(imem_req_o), 32'd0);
            step();
        end
        applyIdle();
        step();
        checkOutput("validOneCycle", 32'(instr_valid_o), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every granted request and every
    // instruction decode actually takes (a flushed hand-off is not taken).
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req_o && imem_gnt_i) begin
                if (expReqQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedReq: request at %h, expected none", imem_addr_o);
                end else begin
                    monExpAddr = expReqQ.pop_front();
                    checkOutput("reqAddr", 32'(imem_addr_o), 32'(monExpAddr));
                end
            end
            if (instr_valid_o && instr_ready_i && !flush_o) begin
                if (expInstrQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedInstr: instr %h at %h, expected none",
                             instr_o, instr_pc_o);
                end else begin
                    monExpInstr = expInstrQ.pop_front();
                    checkOutput("instrData", instr_o, monExpInstr[31:0]);
                    checkOutput("instrPc", 32'(instr_pc_o), 32'(monExpInstr[47:32]));
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        applyIdle();
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        checkOutput("rstPc", 32'(pc_o), 32'h0000);
        checkOutput("rstReq", 32'(imem_req_o), 32'd0);
        checkOutput("rstValid", 32'(instr_valid_o), 32'd0);
        checkOutput("rstInstr", instr_o, 32'h0);
        checkOutput("rstInstrPc", 32'(instr_pc_o), 32'h0);
        checkOutput("rstMisalign", 32'(misalign_o), 32'd0);

        // IDLE cycle: no request yet, and a redirect is ignored.
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0500, 1'b0, 16'h0);
        #1;
        checkOutput("idleReq", 32'(imem_req_o), 32'd0);
        checkOutput("idleFlush", 32'(flush_o), 32'd0);
        step();
        checkOutput("firstReq", 32'(imem_req_o), 32'd1);
        checkOutput("idlePcKept", 32'(pc_o), 32'h0000);

        // Sequential fetch.
        fetchOne(16'h0000, 32'h1111_0000, 0);
        fetchOne(16'h0004, 32'h1111_0004, 0);
        fetchOne(16'h0008, 32'h1111_0008, 0);

        // Backpressure for five cycles, then +4.
        fetchOne(16'h000C, 32'h2222_000C, 5);
        fetchOne(16'h0010, 32'h2222_0010, 0);

        // Kill in flight: redirect while waiting, response two cycles later.
        waitReq(16'h0014);
        expReqQ.push_back(16'h0014);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0100, 1'b0, 16'h0);
        #1;
        checkOutput("killFlush", 32'(flush_o), 32'd1);
        step();
        applyIdle();
        #1;
        checkOutput("killFlushPulse", 32'(flush_o), 32'd0);
        checkOutput("killPc", 32'(pc_o), 32'h0100);
        checkOutput("killMisalign", 32'(misalign_o), 32'd0);
        step();
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        checkOutput("killNoValid", 32'(instr_valid_o), 32'd0);
        checkOutput("killReq", 32'(imem_req_o), 32'd1);
        fetchOne(16'h0100, 32'h3333_0100, 0);

        // Simultaneous redirects in REQ without grant: execute wins.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0200, 1'b1, 16'h0300);
        #1;
        checkOutput("bothFlush", 32'(flush_o), 32'd1);
        step();
        checkOutput("bothPc", 32'(pc_o), 32'h0200);
        fetchOne(16'h0200, 32'h4444_0200, 0);

        // Decode redirect coinciding with grant: old address in flight, killed.
        expReqQ.push_back(16'h0204);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0300);
        #1;
        checkOutput("gntRedirFlush", 32'(flush_o), 32'd1);
        step();
        checkOutput("gntRedirPc", 32'(pc_o), 32'h0300);
        applyStimulus(1'b0, 1'b1, 32'hBAD0_0204, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        checkOutput("gntRedirNoValid", 32'(instr_valid_o), 32'd0);

        // Redirect in HOLD with ready=1: instruction dropped, fetch target.
        waitReq(16'h0300);
        expReqQ.push_back(16'h0300);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h5555_0300, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        checkOutput("holdRedirValid", 32'(instr_valid_o), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'h0400, 1'b0, 16'h0);
        #1;
        checkOutput("holdRedirFlush", 32'(flush_o), 32'd1);
        step();
        checkOutput("holdRedirDropped", 32'(instr_valid_o), 32'd0);
        checkOutput("holdRedirPc", 32'(pc_o), 32'h0400);
        fetchOne(16'h0400, 32'h6666_0400, 0);

        // Wrap and misalign.
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 16'h0);
        #1;
        checkOutput("wrapFlush", 32'(flush_o), 32'd1);
        step();
        checkOutput("wrapPc", 32'(pc_o), 32'hFFFC);
        checkOutput("misalignPulse", 32'(misalign_o), 32'd1);
        applyIdle();
        step();
        checkOutput("misalignOnce", 32'(misalign_o), 32'd0);
        fetchOne(16'hFFFC, 32'h7777_FFFC, 0);
        fetchOne(16'h0000, 32'h7777_0000, 0);

        // Reset mid-transaction while an instruction is buffered.
        expReqQ.push_back(16'h0004);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        applyStimulus(1'b0, 1'b1, 32'h8888_0004, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        step();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
        rst = 1'b1;
        step();
        checkOutput("midRstValid", 32'(instr_valid_o), 32'd0);
        checkOutput("midRstPc", 32'(pc_o), 32'h0000);
        checkOutput("midRstReq", 32'(imem_req_o), 32'd0);
        checkOutput("midRstInstr", instr_o, 32'h0);
        rst = 1'b0;
        applyIdle();
        step();
        step();
        checkOutput("restartReq", 32'(imem_req_o), 32'd1);
        checkOutput("restartPc", 32'(pc_o), 32'h0000);

        // Everything pushed must have been consumed.
        checkOutput("reqQueueEmpty", 32'(expReqQ.size()), 32'd0);
        checkOutput("instrQueueEmpty", 32'(expInstrQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch. It owns the fetch PC register and runs a single-outstanding request/grant/response handshake with instruction memory. It also arbitrates the decode-stage (JAL) and execute-stage (branch/JALR) redirect requests. Squashed fetches are dropped before they reach decode. It sits between instruction memory and the decode stage, and replaces free-running PC increment with a handshake-aware sequencer.

## Interface
- ADDR_W, 16, fetch address width
- RESET_PC, 16'h0000, fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ex_redirect_i  in  1  execute-stage redirect (taken branch or JALR)
- ex_target_i  in  ADDR_W  execute-stage target
- id_redirect_i  in  1  decode-stage redirect (JAL)
- id_target_i  in  ADDR_W  decode-stage target
- imem_req_o  out  1  fetch request
- imem_addr_o  out  ADDR_W  fetch address (equals pc_o)
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response data valid
- imem_rdata_i  in  32  response instruction
- instr_valid_o  out  1  instruction to decode valid
- instr_o  out  32  instruction to decode
- instr_pc_o  out  ADDR_W  address of instr_o
- instr_ready_i  in  1  decode accepts instruction
- pc_o  out  ADDR_W  current fetch PC
- flush_o  out  1  redirect accepted this cycle; flush younger stages
- misalign_o  out  1  one-cycle pulse: accepted target had bits[1:0] != 0

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset; moves unconditionally to REQ on the next cycle.
- REQ: imem_req_o=1.
  - On imem_gnt_i, move to WAIT.
- WAIT: waits for imem_rvalid_i.
  - If the kill flag is clear, capture imem_rdata_i into instr_o and pc_o into instr_pc_o, then move to HOLD.
  - If the kill flag is set, discard the response, clear kill, and move to REQ.
- HOLD: instr_valid_o=1.
  - On instr_ready_i, pc_o += 4 and move to REQ.
- Redirect arbitration: ex_redirect_i has priority over id_redirect_i, because the execute-stage instruction is older. Only one redirect is accepted per cycle.
- Accepted redirect, in any state except IDLE:
  - pc_o <= target with bits[1:0] forced to 0.
  - flush_o=1, combinational, in the same cycle.
  - misalign_o pulses on the next cycle if the raw target bits[1:0] != 0.
- Redirect in REQ without grant: the address updates next cycle, and the state stays REQ.
- Redirect in REQ coinciding with grant: the granted old address is in flight. Move to WAIT with kill=1.
- Redirect in WAIT without rvalid: set kill=1. Later redirects before the response overwrite pc_o; the last one wins.
- Redirect in WAIT coinciding with rvalid: discard the response and move to REQ.
- Redirect in HOLD: drop the buffered instruction and move to REQ. This holds even when instr_ready_i=1; the redirect beats the +4 increment.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFC + 4 = 16'h0000.
- Memory contract:
  - Memory samples imem_addr_o only on a cycle with imem_req_o & imem_gnt_i.
  - The address may change while imem_req_o=1 and grant is low, but only due to a redirect.
  - Memory is reset by the same rst.
  - rvalid never arrives outside WAIT; the sequencer ignores it there.

## Timing
- Reset values: pc_o=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, instr_pc_o=0, flush_o=0, misalign_o=0, kill=0, state IDLE.
- Reset mid-transaction abandons any request, buffered instruction or kill flag. Fetch restarts at RESET_PC.
- Best-case latency:
  - Reset release to first imem_req_o: 1 cycle (IDLE).
  - gnt at cycle T, rvalid at earliest T+1.
  - instr_valid_o rises on the cycle after rvalid.
- Throughput: at most one instruction per 3 cycles (REQ, WAIT, HOLD).
- Outputs change only on clk edges except flush_o, which is combinational from the redirect inputs and state (not IDLE).
- instr_o and instr_pc_o are stable while instr_valid_o=1 and instr_ready_i=0.

## Test plan
- Reset then fetch:
  - Stimulus: gnt immediate, rvalid 1 cycle later, ready=1.
  - Required: requests at 0x0000, 0x0004, 0x0008. instr_pc_o matches each address. instr_valid_o high one cycle per instruction.
- Backpressure:
  - Stimulus: ready=0 for 5 cycles in HOLD.
  - Required: instr_o and instr_pc_o held. No new imem_req_o. Next request at +4 after ready=1.
- Kill in flight:
  - Stimulus: ex_redirect_i to 0x0100 in WAIT, rvalid two cycles later.
  - Required: flush_o pulse. Response discarded (no instr_valid_o). Next request at 0x0100.
- Simultaneous redirects:
  - Stimulus: ex_target 0x0200 and id_target 0x0300 in the same cycle.
  - Required: next fetch at 0x0200.
- Redirect in HOLD with ready=1:
  - Required: buffered instruction not repeated. Fetch at the target, not +4.
- Wrap and misalign:
  - Stimulus: redirect to 0xFFFE.
  - Required: fetch 0xFFFC, misalign_o pulses once, next sequential fetch 0x0000.
